// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared constants for the pipeline stage registers.
//   - Per-stage control/data bundle widths (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Bit offsets of the packed fields inside each bundle.
//   - Reset values of the data bundles.
// No ports (package). Imported with: import pipe_pkg::*;
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Generic defaults, sized for the EX/MEM data bundle.
  localparam int DEFAULT_CTRL_W = 8;
  localparam int DEFAULT_DATA_W = 101;

  // IF/ID: ctrl = {pred_taken}; data = {pc[31:0], instr[31:0]}
  localparam int IF_ID_CTRL_W     = 1;
  localparam int IF_ID_DATA_W     = 64;
  localparam int IFD_PRED_TAKEN   = 0;
  localparam int IFD_INSTR_LSB    = 0;
  localparam int IFD_PC_LSB       = 32;

  // ID/EX: ctrl = {alu_op[1:0], alu_src, mem_to_reg[1:0], mem_write, reg_write, mem_read}
  //        data = {pc, rs1_val, rs2_val, imm, rd[4:0]}
  localparam int ID_EX_CTRL_W     = 8;
  localparam int ID_EX_DATA_W     = 133;
  localparam int IDE_MEMREAD      = 0;
  localparam int IDE_REGWRITE     = 1;
  localparam int IDE_MEMWRITE     = 2;
  localparam int IDE_MEMTOREG_LSB = 3;
  localparam int IDE_ALUSRC       = 5;
  localparam int IDE_ALUOP_LSB    = 6;
  localparam int IDE_RD_LSB       = 0;
  localparam int IDE_IMM_LSB      = 5;
  localparam int IDE_RS2_LSB      = 37;
  localparam int IDE_RS1_LSB      = 69;
  localparam int IDE_PC_LSB       = 101;

  // EX/MEM: ctrl = {mem_to_reg[1:0], mem_write, reg_write, mem_read}
  //         data = {pc, alu_result, mem_wdata, rd[4:0]}
  localparam int EX_MEM_CTRL_W    = 5;
  localparam int EX_MEM_DATA_W    = 101;
  localparam int EXM_MEMREAD      = 0;
  localparam int EXM_REGWRITE     = 1;
  localparam int EXM_MEMWRITE     = 2;
  localparam int EXM_MEMTOREG_LSB = 3;
  localparam int EXM_RD_LSB       = 0;
  localparam int EXM_WDATA_LSB    = 5;
  localparam int EXM_ALU_LSB      = 37;
  localparam int EXM_PC_LSB       = 69;

  // MEM/WB: ctrl = {mem_to_reg[1:0], reg_write}
  //         data = {pc, alu_result, mem_rdata, rd[4:0]}
  localparam int MEM_WB_CTRL_W    = 3;
  localparam int MEM_WB_DATA_W    = 101;
  localparam int MWB_REGWRITE     = 0;
  localparam int MWB_MEMTOREG_LSB = 1;
  localparam int MWB_RD_LSB       = 0;
  localparam int MWB_RDATA_LSB    = 5;
  localparam int MWB_ALU_LSB      = 37;
  localparam int MWB_PC_LSB       = 69;

  // Data-bundle reset values.
  localparam logic [IF_ID_DATA_W-1:0]  IF_ID_RST_DATA  = '0;
  localparam logic [ID_EX_DATA_W-1:0]  ID_EX_RST_DATA  = '0;
  localparam logic [EX_MEM_DATA_W-1:0] EX_MEM_RST_DATA = '0;
  localparam logic [MEM_WB_DATA_W-1:0] MEM_WB_RST_DATA = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if : upstream + downstream handshake of one pipeline stage.
//   in_valid/in_ready/in_ctrl/in_data     : upstream side
//   out_valid/out_ready/out_ctrl/out_data : downstream side
// Modports:
//   slave  : the stage register itself
//   master : the surrounding pipeline (or a testbench)
//
// Handshake: a side transfers an entry on a rising clk edge where both
// valid and ready are high; valid must not depend on ready, and ready
// (in_ready) is driven straight from a register.
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg : one valid + ctrl + data register slot.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   kill               clear valid and ctrl, hold data (highest priority)
//   load               capture d_ctrl/d_data and set valid
//   drop               clear valid only (ctrl and data held)
//   d_ctrl, d_data     load values
//   valid, ctrl, data  slot contents
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 101,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

  // Data is only written on a real load, so it is never disturbed by kills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= RST_DATA;
    end else if (load && !kill) begin
      data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg : parametrised inter-stage pipeline register with a
// valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Ports:
//   clk, rst_n   pipeline clock (rising edge), asynchronous active-low reset
//   flush        synchronous kill of every held entry (priority over all)
//   bus          pipe_stage_reg_if.slave: in_* upstream, out_* downstream
//   stall_cnt    [31:0] cycles with out_valid & !out_ready  (PIPE_STAGE_PERF_EN)
//   bubble_cnt   [31:0] flushes that killed a valid entry   (PIPE_STAGE_PERF_EN)
// Optional feature: define PIPE_STAGE_PERF_EN to add the two counters.
// The main slot drives the outputs; the skid slot catches the single entry
// that can arrive while the main slot is full and stalled.
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = DEFAULT_CTRL_W,
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  pipe_stage_reg_if.slave        bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic              in_fire;
  logic              m_free;
  logic              m_load, m_drop, s_load, s_drop;
  logic [CTRL_W-1:0] m_d_ctrl;
  logic [DATA_W-1:0] m_d_data;

  // in_ready comes straight from the skid valid flop, so it never depends
  // combinationally on out_ready.
  assign in_fire = bus.in_valid & ~s_valid;
  assign m_free  = ~m_valid | bus.out_ready;

  // Main slot refills from the skid first to keep FIFO order.
  assign m_load   = m_free & (s_valid | in_fire);
  assign m_drop   = m_free & ~s_valid & ~in_fire;
  assign m_d_ctrl = s_valid ? s_ctrl : bus.in_ctrl;
  assign m_d_data = s_valid ? s_data : bus.in_data;

  // Skid only catches while main is full and stalled; it empties whenever
  // main can take its entry.
  assign s_load = ~m_free & in_fire;
  assign s_drop = m_free & s_valid;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .load   (m_load),
    .drop   (m_drop),
    .d_ctrl (m_d_ctrl),
    .d_data (m_d_data),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .load   (s_load),
    .drop   (s_drop),
    .d_ctrl (bus.in_ctrl),
    .d_data (bus.in_data),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );

  assign bus.in_ready  = ~s_valid;
  assign bus.out_valid = m_valid;
  // Bubbles never present side-effecting control bits downstream.
  assign bus.out_ctrl  = m_valid ? m_ctrl : '0;
  assign bus.out_data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (m_valid && !bus.out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (m_valid || s_valid)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
